// File: rtl/id_hazard_ctrl.sv
// Decode-stage hazard control: load-use / branch-in-ID stall detection, branch operand forwarding, stall counter.
// Zero-latency stall outputs in RUN; a load feeding a branch from EX holds the pipe one extra cycle in HOLD.
module id_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       id_op,
    input  logic [5:0]       id_func,
    input  logic [4:0]       id_rs_field,
    input  logic [4:0]       id_rt_field,
    input  logic [4:0]       ex_rd,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic [4:0]       mem_rd,
    input  logic             mem_reg_write,
    input  logic             mem_mem_read,
    input  logic             clr_cnt,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             control_sel,
    output logic             forward_c,
    output logic             forward_d,
    output logic             stall,
    output logic [1:0]       hazard_kind,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [1:0] HK_NONE     = 2'd0;
    localparam logic [1:0] HK_LOAD_USE = 2'd1;
    localparam logic [1:0] HK_BR_ALU   = 2'd2;
    localparam logic [1:0] HK_BR_LOAD  = 2'd3;

    state_t           state_q, state_d;
    logic             rem_q, rem_d;
    logic [1:0]       hk_q, hk_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       id_branch;
    logic       uses_rs;
    logic       uses_rt;
    logic       ex_match;
    logic       mem_match;
    logic [1:0] hz_kind;
    logic       hz_long;
    logic       stall_int;

    always_comb begin
        id_branch = (id_op == 6'b000100) || (id_op == 6'b000101) ||
                    (id_op == 6'b000110) || (id_op == 6'b000111) ||
                    (id_op == 6'b000001) ||
                    ((id_op == 6'b000000) &&
                     ((id_func == 6'b001000) || (id_func == 6'b001001)));
        uses_rs   = !((id_op == 6'b000010) || (id_op == 6'b000011) ||
                      (id_op == 6'b001111));
        uses_rt   = (id_op == 6'b000000) || (id_op == 6'b000100) ||
                    (id_op == 6'b000101) || (id_op[5:3] == 3'b101);
    end

    // $0 is never a real producer, so a zero destination can not match.
    always_comb begin
        ex_match  = (ex_rd != 5'd0) &&
                    ((uses_rs && (ex_rd == id_rs_field)) ||
                     (uses_rt && (ex_rd == id_rt_field)));
        mem_match = (mem_rd != 5'd0) &&
                    ((uses_rs && (mem_rd == id_rs_field)) ||
                     (uses_rt && (mem_rd == id_rt_field)));
    end

    always_comb begin
        hz_kind = HK_NONE;
        hz_long = 1'b0;
        if (id_branch && ex_mem_read && ex_reg_write && ex_match) begin
            hz_kind = HK_BR_LOAD;
            hz_long = 1'b1;
        end else if (id_branch && ex_reg_write && !ex_mem_read && ex_match) begin
            hz_kind = HK_BR_ALU;
        end else if (id_branch && mem_mem_read && mem_reg_write && mem_match) begin
            hz_kind = HK_BR_LOAD;
        end else if (!id_branch && ex_mem_read && ex_reg_write && ex_match) begin
            hz_kind = HK_LOAD_USE;
        end
    end

    // Reset gates the outputs directly so an in-flight HOLD is released at once.
    always_comb begin
        stall_int   = 1'b0;
        hazard_kind = HK_NONE;
        if (reset) begin
            if (state_q == HOLD) begin
                stall_int   = 1'b1;
                hazard_kind = hk_q;
            end else begin
                stall_int   = (hz_kind != HK_NONE);
                hazard_kind = hz_kind;
            end
        end
        pc_write    = !stall_int;
        if_id_write = !stall_int;
        control_sel = !stall_int;
        stall       = stall_int;
    end

    always_comb begin
        forward_c = reset && id_branch && mem_reg_write && !mem_mem_read &&
                    (mem_rd != 5'd0) && (mem_rd == id_rs_field);
        forward_d = reset && id_branch && uses_rt && mem_reg_write && !mem_mem_read &&
                    (mem_rd != 5'd0) && (mem_rd == id_rt_field);
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        hk_d    = hk_q;
        case (state_q)
            RUN: begin
                if (hz_long) begin
                    state_d = HOLD;
                    rem_d   = 1'b0;
                    hk_d    = hz_kind;
                end
            end
            HOLD: begin
                if (rem_q == 1'b0) begin
                    state_d = RUN;
                end else begin
                    rem_d = rem_q - 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (stall_int && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            rem_q   <= 1'b0;
            hk_q    <= HK_NONE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            hk_q    <= hk_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stall_cycles = cnt_q;

endmodule
